// File: rtl/ramb4_s4_byte_bridge.sv
// ramb4_s4_byte_bridge
//
// Byte-wide request/acknowledge front end for a 1024 x 4 single-port block
// RAM (X_RAMB4_S4). Each byte access is split into two nibble accesses on
// the RAM port, so the RAM holds 512 bytes. Read nibbles come back from the
// RAM's registered output one cycle after they are addressed, and are put
// back together into one byte.
//
// Parameters
//   NIB_ORDER  0: byte bits [3:0] live at RAM address {BADDR,0} and bits
//                 [7:4] live at {BADDR,1}
//              1: the two nibbles are swapped
//
// Ports
//   CLK       in   1   single clock, shared with the RAM
//   RST       in   1   synchronous active-high reset
//   REQ       in   1   access request
//   WR        in   1   1 = write, 0 = read, sampled with REQ
//   BADDR     in   9   byte address
//   BDI       in   8   write data
//   BUSY      out  1   high whenever the FSM is not IDLE
//   ACK       out  1   one-cycle completion pulse
//   BDO       out  8   read data, valid with ACK on a read, then held
//   RAM_ADDR  out  10  RAM address
//   RAM_DI    out  4   RAM write data
//   RAM_EN    out  1   RAM enable
//   RAM_WE    out  1   RAM write enable
//   RAM_RST   out  1   RAM output reset, always 0
//   RAM_DO    in   4   RAM read data (registered inside the RAM)

module ramb4_s4_byte_bridge #(
    parameter int unsigned NIB_ORDER = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ,
    input  logic       WR,
    input  logic [8:0] BADDR,
    input  logic [7:0] BDI,
    output logic       BUSY,
    output logic       ACK,
    output logic [7:0] BDO,
    output logic [9:0] RAM_ADDR,
    output logic [3:0] RAM_DI,
    output logic       RAM_EN,
    output logic       RAM_WE,
    output logic       RAM_RST,
    input  logic [3:0] RAM_DO
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR0   = 3'd1,
        WR1   = 3'd2,
        RD0   = 3'd3,
        RD1   = 3'd4,
        RD2   = 3'd5,
        RDONE = 3'd6
    } state_t;

    state_t     r_state;
    logic [8:0] r_baddr;
    logic [7:0] r_bdi;
    logic [3:0] r_nib;
    logic [7:0] r_bdo;
    logic       r_busy;
    logic       r_ack;
    logic [9:0] r_ramAddr;
    logic [3:0] r_ramDi;
    logic       r_ramEn;
    logic       r_ramWe;

    state_t     w_nextState;
    logic       w_accept;
    logic [8:0] w_nextBaddr;
    logic [7:0] w_nextBdi;
    logic [3:0] w_nextNib;
    logic [7:0] w_nextBdo;
    logic       w_nextAck;
    logic [9:0] w_nextRamAddr;
    logic [3:0] w_nextRamDi;
    logic       w_nextRamEn;
    logic       w_nextRamWe;
    logic [3:0] w_reqFirstNib;
    logic [3:0] w_heldSecondNib;
    logic [7:0] w_assembledByte;

    // Nibble steering. The first nibble goes out in the same edge that
    // accepts the request, so it is taken straight from BDI; the second one
    // goes out a cycle later and comes from the latched copy.
    assign w_reqFirstNib   = (NIB_ORDER == 0) ? BDI[3:0]   : BDI[7:4];
    assign w_heldSecondNib = (NIB_ORDER == 0) ? r_bdi[7:4] : r_bdi[3:0];
    assign w_assembledByte = (NIB_ORDER == 0) ? {RAM_DO, r_nib}
                                              : {r_nib, RAM_DO};

    // Every output is registered, so this block computes the values that
    // belong to the state being entered rather than the current one.
    // The last cycle of an access (WR1, RDONE) also samples REQ, which lets
    // a held REQ start the next access with no idle cycle in between; the
    // samples taken in the middle of an access are simply not looked at.
    always_comb begin
        w_nextState   = r_state;
        w_accept      = 1'b0;
        w_nextBaddr   = r_baddr;
        w_nextBdi     = r_bdi;
        w_nextNib     = r_nib;
        w_nextBdo     = r_bdo;
        w_nextAck     = 1'b0;
        w_nextRamAddr = r_ramAddr;
        w_nextRamDi   = 4'h0;
        w_nextRamEn   = 1'b0;
        w_nextRamWe   = 1'b0;

        case (r_state)
            IDLE: begin
                w_accept = REQ;
            end
            WR0: begin
                w_nextState   = WR1;
                w_nextRamAddr = {r_baddr, 1'b1};
                w_nextRamDi   = w_heldSecondNib;
                w_nextRamEn   = 1'b1;
                w_nextRamWe   = 1'b1;
                w_nextAck     = 1'b1;
            end
            WR1: begin
                w_nextState = IDLE;
                w_accept    = REQ;
            end
            RD0: begin
                w_nextState   = RD1;
                w_nextRamAddr = {r_baddr, 1'b1};
                w_nextRamEn   = 1'b1;
            end
            RD1: begin
                // RAM_DO now shows the nibble addressed during RD0.
                w_nextState = RD2;
                w_nextNib   = RAM_DO;
            end
            RD2: begin
                // RAM_DO now shows the nibble addressed during RD1; this is
                // the only place BDO is ever loaded.
                w_nextState = RDONE;
                w_nextBdo   = w_assembledByte;
                w_nextAck   = 1'b1;
            end
            RDONE: begin
                w_nextState = IDLE;
                w_accept    = REQ;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        // A new request overrides the return-to-idle of the final cycle.
        if (w_accept) begin
            w_nextBaddr   = BADDR;
            w_nextBdi     = BDI;
            w_nextRamAddr = {BADDR, 1'b0};
            w_nextRamEn   = 1'b1;
            if (WR) begin
                w_nextState = WR0;
                w_nextRamWe = 1'b1;
                w_nextRamDi = w_reqFirstNib;
            end else begin
                w_nextState = RD0;
            end
        end
    end

    // State and output registers. Reset wins over any request in the same
    // cycle and clears everything, including the captured read data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_baddr   <= 9'h000;
            r_bdi     <= 8'h00;
            r_nib     <= 4'h0;
            r_bdo     <= 8'h00;
            r_busy    <= 1'b0;
            r_ack     <= 1'b0;
            r_ramAddr <= 10'h000;
            r_ramDi   <= 4'h0;
            r_ramEn   <= 1'b0;
            r_ramWe   <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_baddr   <= w_nextBaddr;
            r_bdi     <= w_nextBdi;
            r_nib     <= w_nextNib;
            r_bdo     <= w_nextBdo;
            r_busy    <= (w_nextState != IDLE);
            r_ack     <= w_nextAck;
            r_ramAddr <= w_nextRamAddr;
            r_ramDi   <= w_nextRamDi;
            r_ramEn   <= w_nextRamEn;
            r_ramWe   <= w_nextRamWe;
        end
    end

    assign BUSY     = r_busy;
    assign ACK      = r_ack;
    assign BDO      = r_bdo;
    assign RAM_ADDR = r_ramAddr;
    assign RAM_DI   = r_ramDi;
    assign RAM_EN   = r_ramEn;
    assign RAM_WE   = r_ramWe;
    assign RAM_RST  = 1'b0;

endmodule
